xcore_if_bpu_gshare: RTL and testbench
======================================

Name: xcore_if_bpu_gshare

Overview:
Next-generation IF-stage branch prediction unit. It holds its own speculative global history register (GHR), a gshare pattern history table (PHT) of 2-bit counters, and a tagged direct-mapped BTB for indirect (jalr) targets. It predicts on predecoded fetch instructions and is trained and recovered by the writeback branch-resolution port. It sits between predecode (mdec) and the pc mux; write-back bjp (wb_bjp) drives the update port.

Parameters:
XLEN, 32, address/data width
GHR_W, 8, global history length; PHT depth = 2**GHR_W
BTB_IDX_W, 4, BTB index width; BTB depth = 2**BTB_IDX_W
REDIR_GAP, 1, minimum idle cycles forced after each redirect (0 = back-to-back allowed)
RAS_DEPTH, 4, return-stack entries (used only with the optional feature)

Ports:
i_sys_clk  in  1  clock
i_sys_rst  in  1  asynchronous active-low reset
i_pref_instr_vld  in  1  predecoded instruction valid
i_pref_instr_pc  in  XLEN  instruction PC
i_mdec_b / i_mdec_jal / i_mdec_jalr  in  1 each  instruction type (one-hot or all zero)
i_mdec_call / i_mdec_ret  in  1 each  jal/jalr link hints (consumed only with RAS)
i_mdec_ofs  in  XLEN  b/jal immediate offset
o_bpu_redir  out  1  redirect fetch this cycle
o_bpu_target  out  XLEN  redirect target
o_bpu_bits  out  2  PHT counter used, forwarded to wb_bjp
o_bpu_ghr_snap  out  GHR_W  GHR value before this prediction, travels with the instruction
i_wb_upd_vld  in  1  resolved branch/jump update
i_wb_upd_pc  in  XLEN  resolved PC
i_wb_upd_type  in  3  {b, jal, jalr}
i_wb_upd_taken  in  1  actual outcome
i_wb_upd_target  in  XLEN  actual target
i_wb_upd_ghr  in  GHR_W  snapshot returned with the instruction
i_wb_mispred  in  1  misprediction: restore GHR and flush

Behaviour:
- Reset (async): GHR=0; all PHT counters=2'b01 (weakly not-taken); all BTB valid bits=0; gap counter=0; RAS pointer=0.
- Reset outputs: o_bpu_redir=0, o_bpu_target=0, o_bpu_bits=01, o_bpu_ghr_snap=0.
- Prediction path is combinational with zero-cycle latency (async read of PHT/BTB). Only state is written at the clock edge.
- PHT index = i_pref_instr_pc[GHR_W+1:2] XOR GHR.
- BTB index = pc[BTB_IDX_W+1:2]; tag = pc[XLEN-1:BTB_IDX_W+2].
- Decision (pred_vld = i_pref_instr_vld & gap==0 & ~i_wb_mispred):
  - b: redir = ctr[1]; target = pc + ofs (mod 2**XLEN).
  - jal: redir = 1; target = pc + ofs.
  - jalr: redir = BTB hit (valid & tag match & stored type==jalr); target = BTB target.
  - otherwise: redir = 0, target = 0.
- o_bpu_bits = indexed counter regardless of type. o_bpu_ghr_snap = current GHR.
- Speculative GHR: when pred_vld & b, GHR <= {GHR[GHR_W-2:0], ctr[1]}.
- Recovery: on i_wb_mispred, GHR <= {i_wb_upd_ghr[GHR_W-2:0], i_wb_upd_taken} if type b, else GHR <= i_wb_upd_ghr.
  - Mispredict overrides a same-cycle speculative shift.
  - Prediction is suppressed that cycle (redir=0).
- PHT training: when i_wb_upd_vld & type b, the counter at (upd_pc index XOR upd_ghr) saturates up on taken, down on not-taken (00 and 11 hold).
- Same-index PHT write and read in the same cycle: the read returns the old value. No bypass.
- BTB training: when i_wb_upd_vld & type jalr & taken, write valid/tag/type/target. Always overwrite; no replacement policy.
- Throttle: each asserted o_bpu_redir loads gap <= REDIR_GAP; gap decrements to 0. REDIR_GAP=0 disables throttling.

Optional Feature:
XCORE_BPU_RAS_EN.
- Enabled: RAS_DEPTH-entry circular return stack.
  - pred_vld & jal & call pushes pc+4.
  - pred_vld & jalr & ret pops; redir=1 with target = top of stack. This overrides the BTB.
  - Overflow wraps and overwrites the oldest entry. Popping an empty stack falls back to the BTB.
  - i_wb_mispred resets the pointer and count to 0.
- Disabled: i_mdec_call and i_mdec_ret are ignored and jalr uses the BTB only.

Decomposition:
- Shared package (params): type encodings (B=3'b100, JAL=3'b010, JALR=3'b001), PHT reset value 2'b01, counter-saturate function.
- Natural sub-module: xcore_bpu_ras (push/pop/flush, top output), instantiated under the macro.

Test Plan:
- Reset, then b at pc=0x100 with ofs=0x40 → redir=0, bits=01, GHR becomes 0x00 (shift in 0).
- Two wb taken updates at pc=0x100 with ghr=0 → counter 11; b at 0x100 with GHR=0 → redir=1, target=0x140, GHR=0x01.
- jal at 0x200, ofs=-8 (0xFFFFFFF8) → redir=1, target=0x1F8. With REDIR_GAP=1, a jal on the next cycle → redir=0.
- jalr at 0x300 before training → redir=0. After a wb jalr update with target 0x8000 → redir=1, target=0x8000. An aliasing pc with a different tag → redir=0.
- i_wb_mispred with upd_ghr=0xA5, b, taken=1, coincident with a fetch b → GHR=0x4B, redir=0 that cycle.
- RAS_EN: call jal at 0x400, then ret jalr → redir=1, target=0x404. Five pushes with depth 4 → pops return the latest four, then fall back to the BTB.

Source files
------------

// File: rtl/xcore_if_bpu_gshare_pkg.sv
// xcore_if_bpu_gshare_pkg
// Shared definitions for the IF-stage gshare branch prediction unit:
// branch-type encodings used on the writeback update port and in the BTB,
// the PHT counter reset value, and the 2-bit saturating counter update.
// Optional feature macro used by the block: XCORE_BPU_RAS_EN.
package xcore_if_bpu_gshare_pkg;

  // Type encoding on i_wb_upd_type and in BTB entries: {b, jal, jalr}
  localparam logic [2:0] TYPE_B    = 3'b100;
  localparam logic [2:0] TYPE_JAL  = 3'b010;
  localparam logic [2:0] TYPE_JALR = 3'b001;

  // Weakly not-taken
  localparam logic [1:0] PHT_RST_VAL = 2'b01;

  // 2-bit saturating counter: 00 and 11 hold at the ends
  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != 2'b11)) nxt = ctr + 2'b01;
    else if (!taken && (ctr != 2'b00)) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/xcore_if_bpu_gshare_ras.sv
// xcore_bpu_ras
// Circular return-address stack used by the gshare BPU when XCORE_BPU_RAS_EN
// is defined. Overflow wraps and silently overwrites the oldest entry; the
// occupancy count saturates at DEPTH so that popping never returns more
// entries than were actually retained.
// Ports:
//   i_sys_clk, i_sys_rst : clock, asynchronous active-low reset
//   i_push, i_push_data  : push a return address
//   i_pop                : pop the top entry (ignored while empty)
//   i_flush              : reset pointer and count (mispredict recovery)
//   o_top                : current top-of-stack value
//   o_empty              : no retained entries
module xcore_bpu_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            i_sys_clk,
  input  logic            i_sys_rst,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_push_data,
  input  logic            i_pop,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;    // next write slot
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_nxt_ptr;

  assign w_top_idx = (r_ptr == '0) ? PTR_W'(DEPTH - 1) : r_ptr - 1'b1;
  assign w_nxt_ptr = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == '0);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
      r_ptr        <= w_nxt_ptr;
      if (r_cnt != CNT_W'(DEPTH)) r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/xcore_if_bpu_gshare.sv
// xcore_if_bpu_gshare
// IF-stage branch prediction unit: speculative GHR, gshare PHT of 2-bit
// counters, tagged direct-mapped BTB for jalr targets, redirect throttle.
// Prediction is purely combinational from the predecoded instruction; only
// GHR/PHT/BTB/throttle state changes at the clock edge.
// Optional feature: define XCORE_BPU_RAS_EN to add a return-address stack
// (xcore_bpu_ras) that predicts ret-hinted jalr ahead of the BTB.
// Ports:
//   i_sys_clk, i_sys_rst        : clock, asynchronous active-low reset
//   i_pref_instr_vld/_pc        : predecoded instruction valid and PC
//   i_mdec_b/_jal/_jalr         : instruction type (one-hot or all zero)
//   i_mdec_call/_ret            : link hints (RAS build only)
//   i_mdec_ofs                  : b/jal immediate offset
//   o_bpu_redir/_target         : redirect fetch this cycle and its target
//   o_bpu_bits                  : PHT counter read for this PC
//   o_bpu_ghr_snap              : GHR before this prediction
//   i_wb_upd_*                  : resolved branch training port
//   i_wb_mispred                : restore GHR, suppress prediction
// Valid semantics: i_pref_instr_vld and i_wb_upd_vld are single-cycle
// qualifiers with no back-pressure; the unit consumes every valid beat.
module xcore_if_bpu_gshare
  import xcore_if_bpu_gshare_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int GHR_W     = 8,
  parameter int BTB_IDX_W = 4,
  parameter int REDIR_GAP = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_pref_instr_vld,
  input  logic [XLEN-1:0]  i_pref_instr_pc,
  input  logic             i_mdec_b,
  input  logic             i_mdec_jal,
  input  logic             i_mdec_jalr,
  input  logic             i_mdec_call,
  input  logic             i_mdec_ret,
  input  logic [XLEN-1:0]  i_mdec_ofs,
  output logic             o_bpu_redir,
  output logic [XLEN-1:0]  o_bpu_target,
  output logic [1:0]       o_bpu_bits,
  output logic [GHR_W-1:0] o_bpu_ghr_snap,
  input  logic             i_wb_upd_vld,
  input  logic [XLEN-1:0]  i_wb_upd_pc,
  input  logic [2:0]       i_wb_upd_type,
  input  logic             i_wb_upd_taken,
  input  logic [XLEN-1:0]  i_wb_upd_target,
  input  logic [GHR_W-1:0] i_wb_upd_ghr,
  input  logic             i_wb_mispred
);

  localparam int PHT_D = 1 << GHR_W;
  localparam int BTB_D = 1 << BTB_IDX_W;
  localparam int TAG_W = XLEN - BTB_IDX_W - 2;
  localparam int GAP_W = (REDIR_GAP > 1) ? $clog2(REDIR_GAP + 1) : 1;

  logic [GHR_W-1:0] r_ghr;
  logic [1:0]       r_pht     [PHT_D];
  logic             r_btb_vld [BTB_D];
  logic [TAG_W-1:0] r_btb_tag [BTB_D];
  logic [2:0]       r_btb_typ [BTB_D];
  logic [XLEN-1:0]  r_btb_tgt [BTB_D];
  logic [GAP_W-1:0] r_gap;

  logic [GHR_W-1:0]     w_pht_idx;
  logic [GHR_W-1:0]     w_upd_idx;
  logic [1:0]           w_ctr;
  logic [BTB_IDX_W-1:0] w_btb_idx;
  logic [TAG_W-1:0]     w_btb_tag;
  logic [BTB_IDX_W-1:0] w_upd_btb_idx;
  logic                 w_btb_hit;
  logic                 w_pred_vld;
  logic [XLEN-1:0]      w_seq_tgt;
  logic                 w_ras_hit;
  logic [XLEN-1:0]      w_ras_top;
  logic                 w_unused_ok;

  assign w_pht_idx     = i_pref_instr_pc[GHR_W+1:2] ^ r_ghr;
  assign w_upd_idx     = i_wb_upd_pc[GHR_W+1:2] ^ i_wb_upd_ghr;
  assign w_ctr         = r_pht[w_pht_idx];
  assign w_btb_idx     = i_pref_instr_pc[BTB_IDX_W+1:2];
  assign w_btb_tag     = i_pref_instr_pc[XLEN-1:BTB_IDX_W+2];
  assign w_upd_btb_idx = i_wb_upd_pc[BTB_IDX_W+1:2];
  assign w_btb_hit     = r_btb_vld[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_btb_tag)
                         && (r_btb_typ[w_btb_idx] == TYPE_JALR);
  assign w_pred_vld    = i_pref_instr_vld && (r_gap == '0) && !i_wb_mispred;
  assign w_seq_tgt     = i_pref_instr_pc + i_mdec_ofs;

  assign o_bpu_bits     = w_ctr;
  assign o_bpu_ghr_snap = r_ghr;

  // Instruction-aligned low PC bits never index anything
  assign w_unused_ok = ^{i_pref_instr_pc[1:0], i_wb_upd_pc[1:0], i_mdec_call, i_mdec_ret};

`ifdef XCORE_BPU_RAS_EN
  logic w_ras_empty;
  logic w_ras_push;

  assign w_ras_push = w_pred_vld && i_mdec_jal && i_mdec_call;
  // An empty stack falls through to the BTB lookup
  assign w_ras_hit  = w_pred_vld && i_mdec_jalr && i_mdec_ret && !w_ras_empty;

  xcore_bpu_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst   (i_sys_rst),
    .i_push      (w_ras_push),
    .i_push_data (i_pref_instr_pc + XLEN'(4)),
    .i_pop       (w_ras_hit),
    .i_flush     (i_wb_mispred),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty)
  );
`else
  assign w_ras_hit = 1'b0;
  assign w_ras_top = '0;
`endif

  always_comb begin
    o_bpu_redir  = 1'b0;
    o_bpu_target = '0;
    if (w_pred_vld) begin
      if (i_mdec_b) begin
        o_bpu_redir  = w_ctr[1];
        o_bpu_target = w_seq_tgt;
      end else if (i_mdec_jal) begin
        o_bpu_redir  = 1'b1;
        o_bpu_target = w_seq_tgt;
      end else if (i_mdec_jalr) begin
        if (w_ras_hit) begin
          o_bpu_redir  = 1'b1;
          o_bpu_target = w_ras_top;
        end else if (w_btb_hit) begin
          o_bpu_redir  = 1'b1;
          o_bpu_target = r_btb_tgt[w_btb_idx];
        end
      end
    end
  end

  // Mispredict recovery wins over the same-cycle speculative shift
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_ghr <= '0;
    end else if (i_wb_mispred) begin
      if (i_wb_upd_type == TYPE_B) r_ghr <= {i_wb_upd_ghr[GHR_W-2:0], i_wb_upd_taken};
      else                         r_ghr <= i_wb_upd_ghr;
    end else if (w_pred_vld && i_mdec_b) begin
      r_ghr <= {r_ghr[GHR_W-2:0], w_ctr[1]};
    end
  end

  // No write-to-read bypass: a same-index fetch sees the pre-update counter
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      for (int i = 0; i < PHT_D; i++) r_pht[i] <= PHT_RST_VAL;
    end else if (i_wb_upd_vld && (i_wb_upd_type == TYPE_B)) begin
      r_pht[w_upd_idx] <= sat_ctr(r_pht[w_upd_idx], i_wb_upd_taken);
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      for (int i = 0; i < BTB_D; i++) begin
        r_btb_vld[i] <= 1'b0;
        r_btb_tag[i] <= '0;
        r_btb_typ[i] <= '0;
        r_btb_tgt[i] <= '0;
      end
    end else if (i_wb_upd_vld && (i_wb_upd_type == TYPE_JALR) && i_wb_upd_taken) begin
      r_btb_vld[w_upd_btb_idx] <= 1'b1;
      r_btb_tag[w_upd_btb_idx] <= i_wb_upd_pc[XLEN-1:BTB_IDX_W+2];
      r_btb_typ[w_upd_btb_idx] <= i_wb_upd_type;
      r_btb_tgt[w_upd_btb_idx] <= i_wb_upd_target;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_gap <= '0;
    end else if (o_bpu_redir) begin
      r_gap <= GAP_W'(REDIR_GAP);
    end else if (r_gap != '0) begin
      r_gap <= r_gap - 1'b1;
    end
  end

endmodule

// File: tb/tb_xcore_if_bpu_gshare.sv
module tb_xcore_if_bpu_gshare;
  localparam int XLEN = 32;
  localparam int GHR_W = 8;
  localparam int EW = 1 + XLEN + 2 + GHR_W;
  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_B    = 3'b100;
  localparam logic [2:0] T_JAL  = 3'b010;
  localparam logic [2:0] T_JALR = 3'b001;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             pref_vld;
  logic [XLEN-1:0]  pref_pc;
  logic             mdec_b, mdec_jal, mdec_jalr, mdec_call, mdec_ret;
  logic [XLEN-1:0]  mdec_ofs;
  logic             bpu_redir;
  logic [XLEN-1:0]  bpu_target;
  logic [1:0]       bpu_bits;
  logic [GHR_W-1:0] bpu_ghr_snap;
  logic             upd_vld;
  logic [XLEN-1:0]  upd_pc;
  logic [2:0]       upd_type;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic [GHR_W-1:0] upd_ghr;
  logic             mispred;

  xcore_if_bpu_gshare #(
    .XLEN(XLEN), .GHR_W(GHR_W), .BTB_IDX_W(4), .REDIR_GAP(1), .RAS_DEPTH(4)
  ) dut (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst_n),
    .i_pref_instr_vld (pref_vld),
    .i_pref_instr_pc  (pref_pc),
    .i_mdec_b         (mdec_b),
    .i_mdec_jal       (mdec_jal),
    .i_mdec_jalr      (mdec_jalr),
    .i_mdec_call      (mdec_call),
    .i_mdec_ret       (mdec_ret),
    .i_mdec_ofs       (mdec_ofs),
    .o_bpu_redir      (bpu_redir),
    .o_bpu_target     (bpu_target),
    .o_bpu_bits       (bpu_bits),
    .o_bpu_ghr_snap   (bpu_ghr_snap),
    .i_wb_upd_vld     (upd_vld),
    .i_wb_upd_pc      (upd_pc),
    .i_wb_upd_type    (upd_type),
    .i_wb_upd_taken   (upd_taken),
    .i_wb_upd_target  (upd_target),
    .i_wb_upd_ghr     (upd_ghr),
    .i_wb_mispred     (mispred)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  logic          chk_en = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  // driver tasks
  task automatic clear_inputs();
    pref_vld = 1'b0; pref_pc = '0; mdec_b = 1'b0; mdec_jal = 1'b0; mdec_jalr = 1'b0;
    mdec_call = 1'b0; mdec_ret = 1'b0; mdec_ofs = '0;
    upd_vld = 1'b0; upd_pc = '0; upd_type = '0; upd_taken = 1'b0; upd_target = '0;
    upd_ghr = '0; mispred = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
    chk_en = 1'b0;
  endtask

  task automatic fetch(input logic [XLEN-1:0] pc, input logic [2:0] typ,
                       input logic call, input logic ret, input logic [XLEN-1:0] ofs);
    pref_vld = 1'b1; pref_pc = pc;
    mdec_b = typ[2]; mdec_jal = typ[1]; mdec_jalr = typ[0];
    mdec_call = call; mdec_ret = ret; mdec_ofs = ofs;
  endtask

  task automatic wb(input logic [XLEN-1:0] pc, input logic [2:0] typ, input logic taken,
                    input logic [XLEN-1:0] tgt, input logic [GHR_W-1:0] ghr, input logic mp);
    upd_vld = 1'b1; upd_pc = pc; upd_type = typ; upd_taken = taken;
    upd_target = tgt; upd_ghr = ghr; mispred = mp;
  endtask

  task automatic expect_out(input logic redir, input logic [XLEN-1:0] tgt,
                            input logic [1:0] bits, input logic [GHR_W-1:0] ghr, input string nm);
    exp_q.push_back({redir, tgt, bits, ghr});
    name_q.push_back(nm);
    chk_en = 1'b1;
  endtask

  task automatic check_field(input string nm, input string fld,
                             input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=0x%0h expected=0x%0h", nm, fld, act, exp);
  endtask

  // monitor: outputs are combinational, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
        logic [EW-1:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check_field(nm, "redir",  XLEN'(bpu_redir),    XLEN'(e[EW-1]));
        check_field(nm, "target", bpu_target,          e[EW-2 -: XLEN]);
        check_field(nm, "bits",   XLEN'(bpu_bits),     XLEN'(e[GHR_W+1 -: 2]));
        check_field(nm, "ghr",    XLEN'(bpu_ghr_snap), XLEN'(e[GHR_W-1:0]));
      end
    end
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out(1'b0, 32'h0, 2'b01, 8'h00, "reset");
    tick();
    rst_n = 1'b1;

    // cold branch: weakly not-taken, shifts 0 into GHR
    fetch(32'h100, T_B, 1'b0, 1'b0, 32'h40);
    expect_out(1'b0, 32'h140, 2'b01, 8'h00, "b_cold"); tick();
    wb(32'h100, T_B, 1'b1, 32'h0, 8'h00, 1'b0); tick();
    wb(32'h100, T_B, 1'b1, 32'h0, 8'h00, 1'b0); tick();
    fetch(32'h100, T_B, 1'b0, 1'b0, 32'h40);
    expect_out(1'b1, 32'h140, 2'b11, 8'h00, "b_trained"); tick();
    // throttled cycle after a redirect; GHR now 0x01
    fetch(32'h100, T_B, 1'b0, 1'b0, 32'h40);
    expect_out(1'b0, 32'h0, 2'b01, 8'h01, "b_gap"); tick();
    fetch(32'h200, T_JAL, 1'b0, 1'b0, 32'hFFFF_FFF8);
    expect_out(1'b1, 32'h1F8, 2'b01, 8'h01, "jal_neg"); tick();
    fetch(32'h208, T_JAL, 1'b0, 1'b0, 32'h8);
    expect_out(1'b0, 32'h0, 2'b01, 8'h01, "jal_gap"); tick();
    // BTB
    fetch(32'h300, T_JALR, 1'b0, 1'b0, 32'h0);
    expect_out(1'b0, 32'h0, 2'b01, 8'h01, "jalr_cold"); tick();
    wb(32'h300, T_JALR, 1'b1, 32'h8000, 8'h01, 1'b0); tick();
    fetch(32'h300, T_JALR, 1'b0, 1'b0, 32'h0);
    expect_out(1'b1, 32'h8000, 2'b01, 8'h01, "jalr_hit"); tick();
    tick();
    fetch(32'h340, T_JALR, 1'b0, 1'b0, 32'h0);
    expect_out(1'b0, 32'h0, 2'b01, 8'h01, "jalr_alias"); tick();
    // mispredict coincident with a fetch b: 0xA5 -> {0x25,1} = 0x4B
    wb(32'h500, T_B, 1'b1, 32'h0, 8'hA5, 1'b1);
    fetch(32'h100, T_B, 1'b0, 1'b0, 32'h40);
    expect_out(1'b0, 32'h0, 2'b01, 8'h01, "mispred_fetch"); tick();
    fetch(32'h100, T_NONE, 1'b0, 1'b0, 32'h40);
    expect_out(1'b0, 32'h0, 2'b01, 8'h4B, "ghr_recovered"); tick();
    // same-index write and read: read sees old 01; GHR -> 0x96
    wb(32'h100, T_B, 1'b1, 32'h0, 8'h4B, 1'b0);
    fetch(32'h100, T_B, 1'b0, 1'b0, 32'h40);
    expect_out(1'b0, 32'h140, 2'b01, 8'h4B, "pht_read_old"); tick();
    wb(32'h100, T_B, 1'b1, 32'h0, 8'h4B, 1'b0); tick();
    // 0x274[9:2]=0x9D ^ 0x96 = 0x0B, counter now 11; GHR -> 0x2D
    fetch(32'h274, T_B, 1'b0, 1'b0, 32'h10);
    expect_out(1'b1, 32'h284, 2'b11, 8'h96, "pht_xor_idx"); tick();
    // non-branch mispredict restores the snapshot verbatim
    wb(32'h0, T_JAL, 1'b1, 32'h0, 8'h33, 1'b1); tick();
    fetch(32'h100, T_NONE, 1'b0, 1'b0, 32'h0);
    expect_out(1'b0, 32'h0, 2'b01, 8'h33, "ghr_restore_jal"); tick();
    // idx 0x40: 11 -> 10 -> 01 -> 00 -> 00
    for (int i = 0; i < 4; i++) begin
      wb(32'h100, T_B, 1'b0, 32'h0, 8'h00, 1'b0); tick();
    end
    // 0x1CC[9:2]=0x73 ^ 0x33 = 0x40; GHR -> 0x66
    fetch(32'h1CC, T_B, 1'b0, 1'b0, 32'h4);
    expect_out(1'b0, 32'h1D0, 2'b00, 8'h33, "pht_sat_low"); tick();
    // idx 0x0B already 11, one more taken holds at 11
    wb(32'h100, T_B, 1'b1, 32'h0, 8'h4B, 1'b0); tick();
    // 0x1B4[9:2]=0x6D ^ 0x66 = 0x0B; GHR -> 0xCD
    fetch(32'h1B4, T_B, 1'b0, 1'b0, 32'h20);
    expect_out(1'b1, 32'h1D4, 2'b11, 8'h66, "pht_sat_high"); tick();
    tick();

`ifdef XCORE_BPU_RAS_EN
    fetch(32'h400, T_JAL, 1'b1, 1'b0, 32'h100);
    expect_out(1'b1, 32'h500, 2'b01, 8'hCD, "ras_call"); tick();
    tick();
    fetch(32'h600, T_JALR, 1'b0, 1'b1, 32'h0);
    expect_out(1'b1, 32'h404, 2'b01, 8'hCD, "ras_ret"); tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      fetch(32'h1000 + 32'(i * 16), T_JAL, 1'b1, 1'b0, 32'h100);
      expect_out(1'b1, 32'h1100 + 32'(i * 16), 2'b01, 8'hCD, "ras_push"); tick();
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      fetch(32'h300, T_JALR, 1'b0, 1'b1, 32'h0);
      expect_out(1'b1, 32'h1044 - 32'(i * 16), 2'b01, 8'hCD, "ras_pop"); tick();
      tick();
    end
    fetch(32'h300, T_JALR, 1'b0, 1'b1, 32'h0);
    expect_out(1'b1, 32'h8000, 2'b01, 8'hCD, "ras_empty_btb"); tick();
    tick();
`endif

    tick();
    tick();
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
